// File: rtl/rom_stream_tx_if.sv
// Bus bundle for rom_stream_tx: start/select inputs, ROM bank wiring and serial status outputs.
interface rom_stream_tx_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic                     write;
  logic [NUM_CH-1:0]        ch_sel;
  logic [NUM_CH*DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0]        rom_addr;
  logic                     serial_out;
  logic                     busy;
  logic                     done;
  logic [DATA_W-1:0]        data_latch;

  modport master (
    output write, ch_sel, rom_data,
    input  rom_addr, serial_out, busy, done, data_latch
  );

  modport slave (
    input  write, ch_sel, rom_data,
    output rom_addr, serial_out, busy, done, data_latch
  );
endinterface

// File: rtl/rom_stream_tx.sv
// Streams a DEPTH-word table from one of NUM_CH ROM channels as UART-style serial frames.
// Define ROM_STREAM_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module rom_stream_tx #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned BIT_CYCLES = 434
) (
  input  logic           i_sysclk,
  input  logic           i_rst_n,
  rom_stream_tx_if.slave io_bus
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             r_state, w_state;
  logic               r_write_d;
  logic               r_start_edge;
  logic [CH_W-1:0]    r_ch, w_ch;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [BIT_W-1:0]   r_bit, w_bit;
  logic [ADDR_W-1:0]  r_addr, w_addr;
  logic [DATA_W-1:0]  r_latch, w_latch;
  logic               r_serial, w_serial;
  logic               r_busy, w_busy;
  logic               r_done, w_done;

  logic               w_sel_valid;
  logic [CH_W-1:0]    w_sel_idx;
  logic [DATA_W-1:0]  w_rom_word;
  logic               w_cnt_last;

  // Lowest set switch wins when several are on.
  always_comb begin
    w_sel_valid = |io_bus.ch_sel;
    w_sel_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (io_bus.ch_sel[k]) w_sel_idx = CH_W'(k);
    end
  end

  always_comb begin
    w_rom_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_ch == CH_W'(k)) w_rom_word = io_bus.rom_data[k*DATA_W +: DATA_W];
    end
  end

  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state  = r_state;
    w_ch     = r_ch;
    w_cnt    = r_cnt;
    w_bit    = r_bit;
    w_addr   = r_addr;
    w_latch  = r_latch;
    w_serial = r_serial;
    w_busy   = r_busy;
    w_done   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_serial = 1'b1;
        if (r_start_edge && w_sel_valid) begin
          w_state = S_LOAD;
          w_ch    = w_sel_idx;
          w_busy  = 1'b1;
          w_cnt   = '0;
          w_bit   = '0;
        end
      end

      S_LOAD: begin
        w_latch  = w_rom_word;
        w_state  = S_START;
        w_serial = 1'b0;
        w_cnt    = '0;
      end

      S_START: begin
        if (w_cnt_last) begin
          w_cnt    = '0;
          w_bit    = '0;
          w_state  = S_DATA;
          w_serial = r_latch[0];
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (w_cnt_last) begin
          w_cnt = '0;
          if (r_bit == BIT_LAST) begin
`ifdef ROM_STREAM_PARITY_EN
            w_state  = S_PARITY;
            w_serial = ^r_latch;
`else
            w_state  = S_STOP;
            w_serial = 1'b1;
`endif
          end else begin
            w_bit    = r_bit + BIT_W'(1);
            w_serial = r_latch[r_bit + BIT_W'(1)];
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

`ifdef ROM_STREAM_PARITY_EN
      S_PARITY: begin
        if (w_cnt_last) begin
          w_cnt    = '0;
          w_state  = S_STOP;
          w_serial = 1'b1;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
`endif

      // Last word ends the run; otherwise the next LOAD follows with no extra gap.
      S_STOP: begin
        w_serial = 1'b1;
        if (w_cnt_last) begin
          w_cnt = '0;
          if (r_addr == ADDR_LAST) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_addr  = '0;
          end else begin
            w_state = S_LOAD;
            w_addr  = r_addr + ADDR_W'(1);
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state  = S_IDLE;
        w_serial = 1'b1;
        w_busy   = 1'b0;
        w_addr   = '0;
      end
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_write_d    <= 1'b0;
      r_start_edge <= 1'b0;
      r_ch         <= '0;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_addr       <= '0;
      r_latch      <= '0;
      r_serial     <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_write_d    <= io_bus.write;
      r_start_edge <= io_bus.write & ~r_write_d;
      r_ch         <= w_ch;
      r_cnt        <= w_cnt;
      r_bit        <= w_bit;
      r_addr       <= w_addr;
      r_latch      <= w_latch;
      r_serial     <= w_serial;
      r_busy       <= w_busy;
      r_done       <= w_done;
    end
  end

  assign io_bus.rom_addr   = r_addr;
  assign io_bus.serial_out = r_serial;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.data_latch = r_latch;

endmodule

// File: tb/tb_rom_stream_tx.sv
// Randomized bench for rom_stream_tx: a per-cycle expected waveform is built from frame rules and compared.
module tb_rom_stream_tx;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned BIT_CYCLES = 4;
`ifdef ROM_STREAM_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  localparam int unsigned FRAME_BITS = DATA_W + 2 + PAR_BITS;
  localparam int          ABORT_IDX  = 1 + 2 * (1 + int'(FRAME_BITS * BIT_CYCLES)) + 1
                                       + int'(BIT_CYCLES) + 3 * int'(BIT_CYCLES) + 1;

  typedef struct packed {
    logic              ser;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] latch;
  } samp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_stream_tx_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rom_stream_tx #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BIT_CYCLES(BIT_CYCLES)
  ) dut (
    .i_sysclk(clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  logic [DATA_W-1:0] rom_mem [NUM_CH][1<<ADDR_W];

  always_comb begin
    bus.rom_data = '0;
    for (int k = 0; k < NUM_CH; k++) bus.rom_data[k*DATA_W +: DATA_W] = rom_mem[k][bus.rom_addr];
  end

  int n_chk = 0;
  int n_err = 0;
  samp_t exp_q[$];
  logic [DATA_W-1:0] wq [DEPTH];
  logic [DATA_W-1:0] hold_latch;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic samp_t mk(input logic s, input logic b, input logic d,
                               input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] l);
    samp_t t;
    t.ser = s; t.busy = b; t.done = d; t.addr = a; t.latch = l;
    return t;
  endfunction

  task automatic cmp(input string ctx, input samp_t e);
    check({ctx, ".serial_out"}, 32'(bus.serial_out), 32'(e.ser));
    check({ctx, ".busy"},       32'(bus.busy),       32'(e.busy));
    check({ctx, ".done"},       32'(bus.done),       32'(e.done));
    check({ctx, ".rom_addr"},   32'(bus.rom_addr),   32'(e.addr));
    check({ctx, ".data_latch"}, 32'(bus.data_latch), 32'(e.latch));
  endtask

  function automatic int lowest_ch(input logic [NUM_CH-1:0] sel);
    for (int k = 0; k < NUM_CH; k++) if (sel[k]) return k;
    return -1;
  endfunction

  // Expected samples, one per cycle, starting the cycle after write is driven high.
  function automatic void build_expect();
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] w;
    exp_q.delete();
    prev = hold_latch;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, '0, prev));
    for (int a = 0; a < DEPTH; a++) begin
      w = wq[a];
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, ADDR_W'(a), prev));
      for (int c = 0; c < BIT_CYCLES; c++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, ADDR_W'(a), w));
      for (int b = 0; b < DATA_W; b++)
        for (int c = 0; c < BIT_CYCLES; c++) exp_q.push_back(mk(w[b], 1'b1, 1'b0, ADDR_W'(a), w));
      for (int p = 0; p < PAR_BITS; p++)
        for (int c = 0; c < BIT_CYCLES; c++) exp_q.push_back(mk(^w, 1'b1, 1'b0, ADDR_W'(a), w));
      for (int c = 0; c < BIT_CYCLES; c++) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, ADDR_W'(a), w));
      prev = w;
    end
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, '0, prev));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, '0, prev));
  endfunction

  task automatic check_idle(input string ctx, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmp(ctx, mk(1'b1, 1'b0, 1'b0, '0, hold_latch));
    end
  endtask

  task automatic do_run(input string ctx, input logic [NUM_CH-1:0] sel,
                        input int flip_at, input logic [NUM_CH-1:0] flip_sel,
                        input int tog_at, input int abort_at, input bit hold_write);
    int  ch;
    bit  aborted;
    ch = lowest_ch(sel);
    for (int a = 0; a < DEPTH; a++) wq[a] = rom_mem[ch][a];
    build_expect();
    aborted = 1'b0;
    @(negedge clk);
    bus.ch_sel = sel;
    bus.write  = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      cmp(ctx, exp_q[i]);
      if (i == abort_at) begin
        rst_n     = 1'b0;
        bus.write = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        hold_latch = '0;
        cmp({ctx, ".abort"}, mk(1'b1, 1'b0, 1'b0, '0, '0));
        aborted = 1'b1;
        break;
      end
      if (i == flip_at) bus.ch_sel = flip_sel;
      if (i == tog_at) bus.write = 1'b0;
      if (i == tog_at + 2) bus.write = 1'b1;
    end
    if (!hold_write) bus.write = 1'b0;
    if (!aborted) hold_latch = wq[DEPTH-1];
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.write  = 1'b0;
    bus.ch_sel = '0;
    hold_latch = '0;
    for (int k = 0; k < NUM_CH; k++)
      for (int a = 0; a < (1 << ADDR_W); a++) rom_mem[k][a] = DATA_W'($urandom);
    rom_mem[1][0] = 8'hA5;
    rom_mem[1][1] = 8'h3C;
    rom_mem[1][2] = 8'hFF;
    rom_mem[1][3] = 8'h00;
    rom_mem[2][0] = 8'h01;

    repeat (3) @(negedge clk);
    cmp("reset", mk(1'b1, 1'b0, 1'b0, '0, '0));
    rst_n = 1'b1;
    check_idle("idle_after_reset", 100);

    do_run("single_ch1", 4'b0010, -1, '0, -1, -1, 1'b0);
    check_idle("post_single", 5);

    @(negedge clk);
    bus.ch_sel = '0;
    bus.write  = 1'b1;
    check_idle("no_sel", 20);
    bus.write = 1'b0;
    check_idle("no_sel_release", 3);

    do_run("multi_sel_0110", 4'b0110, -1, '0, -1, -1, 1'b0);
    check_idle("post_multi", 3);

    do_run("flip_sel", 4'b0010, 60, 4'b1000, -1, -1, 1'b0);
    check_idle("post_flip", 3);

    do_run("retrigger", 4'b0100, -1, '0, 50, -1, 1'b0);
    check_idle("post_retrigger", 20);

    do_run("hold_write", 4'b0001, -1, '0, -1, -1, 1'b1);
    check_idle("held_high", 30);
    bus.write = 1'b0;
    check_idle("held_release", 3);

    do_run("abort", 4'b0010, -1, '0, -1, ABORT_IDX, 1'b0);
    check_idle("post_abort", 5);
    do_run("after_abort", 4'b0010, -1, '0, -1, -1, 1'b0);
    check_idle("post_after_abort", 3);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NUM_CH; k++)
        for (int a = 0; a < (1 << ADDR_W); a++) rom_mem[k][a] = DATA_W'($urandom);
      do_run("random", NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1)), -1, '0, -1, -1, 1'b0);
      check_idle("post_random", 2 + int'($urandom_range(0, 5)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rom_stream_tx.md
Name: rom_stream_tx

Overview:
- Parametrised successor to the fixed four-ROM, switch-selected serial sender.
- Streams a DEPTH-word table from one of NUM_CH combinational ROM channels out of a UART-style serial line (start bit, DATA_W data bits LSB first, stop bit).
- The channel is chosen by one-hot switches, which are sampled once at start; a rising edge on write starts a run.
- Provides busy/done status and a latched copy of the word in flight. Sits between the ROM bank and the board pin.

Parameters:
- NUM_CH, 4, number of ROM channels.
- DATA_W, 8, bits per word.
- DEPTH, 16, words sent per run; addresses 0..DEPTH-1.
- ADDR_W, 4, ROM address width; must satisfy 2^ADDR_W >= DEPTH.
- BIT_CYCLES, 434, sysclk cycles per serial bit; minimum 2.

Ports:
- sysclk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- write  in  1  start request; level input, rising edge detected internally.
- ch_sel  in  NUM_CH  one-hot channel switches.
- rom_data  in  NUM_CH*DATA_W  flattened ROM outputs; channel k is at bits [k*DATA_W +: DATA_W].
- rom_addr  out  ADDR_W  shared address to all ROMs.
- serial_out  out  1  serial line, idles high.
- busy  out  1  high from the cycle after the start edge until frame completion.
- done  out  1  one-cycle pulse after the last stop bit of a run.
- data_latch  out  DATA_W  word currently being shifted.

Behaviour:
- Reset (rst_n=0 at a sysclk edge):
  - State IDLE; serial_out=1, busy=0, done=0, rom_addr=0, data_latch=0.
  - Bit counter, cycle counter and edge-detect register cleared. write_d=0, so a write held high through reset release starts a run.
  - Reset mid-run aborts immediately. No partial frame completion; line returns high on the next cycle.
- Start:
  - start_edge = write & ~write_d, registered.
  - In IDLE, a start_edge with ch_sel != 0 latches the channel index and moves to LOAD; busy=1 from that cycle.
  - If several ch_sel bits are set, the lowest index wins.
  - A start_edge with ch_sel=0 is ignored and the block stays IDLE.
  - ch_sel changes after the start edge have no effect until the next run.
  - start_edge while busy is ignored; it is not queued.
- FSM:
  - IDLE -> LOAD on a valid start.
  - LOAD (1 cycle): data_latch <= selected channel rom_data at current rom_addr -> START.
  - START: serial_out=0 for BIT_CYCLES cycles -> DATA.
  - DATA: serial_out=data_latch[bit_idx], bit_idx 0..DATA_W-1, each held BIT_CYCLES cycles -> STOP after bit DATA_W-1.
  - STOP: serial_out=1 for BIT_CYCLES cycles.
    - If rom_addr == DEPTH-1: -> IDLE, with done=1 for exactly one cycle, busy=0, rom_addr=0, all in the same cycle.
    - Otherwise: rom_addr <= rom_addr+1 -> LOAD.
- Timing:
  - Back-to-back words with no idle gap beyond the single LOAD cycle. serial_out stays high during LOAD.
  - Frame length: (DATA_W+2)*BIT_CYCLES cycles. Run length: DEPTH*((DATA_W+2)*BIT_CYCLES+1) cycles from LOAD entry to done.
  - First start bit appears 2 cycles after the sysclk edge on which write is first sampled high (edge-detect register + LOAD).
- Arithmetic and bounds:
  - Cycle counter is $clog2(BIT_CYCLES) bits wide and wraps at BIT_CYCLES-1.
  - rom_addr never exceeds DEPTH-1; when DEPTH < 2^ADDR_W, upper addresses are never driven.
- Other outputs:
  - data_latch holds its last value in IDLE.
  - serial_out is registered, never combinational, so there are no glitches.

Optional Feature:
- Macro: ROM_STREAM_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, driving the even parity bit (XOR of data_latch) for BIT_CYCLES cycles.
  - Frame length becomes (DATA_W+3)*BIT_CYCLES.
- Undefined: no parity state; frame as above.
- All other behaviour is identical in both builds.

Test Plan:
- Bench configuration: BIT_CYCLES=4, DEPTH=4, DATA_W=8, NUM_CH=4.
- Reset/idle: rst_n=0 for 3 cycles, then release with write=0 -> serial_out=1, busy=0, rom_addr=0, no done for 100 cycles.
- Single run: ch_sel=0010, channel 1 ROM = {0xA5,0x3C,0xFF,0x00}, write 0->1 -> four frames decode to exactly those bytes LSB first. Each frame is 40 cycles, with a 1-cycle gap. done pulses once, 164 cycles after LOAD entry.
- Selection rules:
  - ch_sel=0000 plus write edge -> no activity.
  - ch_sel=0110 -> channel 1 data is sent.
  - ch_sel flipped to 1000 mid-run -> stream unchanged.
- Re-trigger and hold:
  - write toggled during busy -> ignored, one run only.
  - write held high after done -> no second run until a new rising edge.
- Reset mid-frame: assert rst_n=0 during bit 3 of word 2 -> next cycle serial_out=1, busy=0, rom_addr=0. A following write edge restarts from address 0.
- Parity build (ROM_STREAM_PARITY_EN): word 0xA5 -> parity bit 0, frame 44 cycles. Word 0x01 -> parity bit 1.
